// File: rtl/seq_multiplier_radix_taint_pkg.sv
// Shared definitions for the taint-tracked radix-2^k sequential multiplier.
//   state_t     : FSM state encoding (IDLE, LOAD, RUN, FIX, DONE)
//   cnt_width() : width of the RUN-cycle counter, able to hold N = WIDTH/BITS_PER_CYCLE
//   smear()     : set every bit at or above the lowest set bit (0 stays 0)
package seq_multiplier_radix_taint_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

    // smear() works on a fixed wide vector; callers zero-extend into it and
    // truncate back. Both steps are exact because the lowest set bit does not
    // move. This covers operand widths up to 128 bits.
    localparam int SMEAR_W = 256;

    function automatic int cnt_width(input int width, input int bits_per_cycle);
        return $clog2(width / bits_per_cycle + 1);
    endfunction

    // x | -x : -x keeps the lowest set bit, clears the bits below it and
    // inverts the bits above it. OR-ing with x therefore sets everything above.
    function automatic logic [SMEAR_W-1:0] smear(input logic [SMEAR_W-1:0] x);
        return x | (-x);
    endfunction

endpackage

// File: rtl/seq_multiplier_radix_taint_if.sv
// Request/response bundle of the multiplier, with a shadow taint bit for
// every signal (suffix _t).
//   master : drives start, signed_mode, multiplier, multiplicand (+ taints)
//   slave  : drives ready, product, productDone (+ taints)
interface seq_multiplier_radix_taint_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 start_t;
    logic                 signed_mode;
    logic                 signed_mode_t;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplier_t;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplicand_t;
    logic                 ready;
    logic                 ready_t;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_t;
    logic                 productDone;
    logic                 productDone_t;

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
               multiplier, multiplier_t, multiplicand, multiplicand_t,
        input  ready, ready_t, product, product_t, productDone, productDone_t
    );

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
               multiplier, multiplier_t, multiplicand, multiplicand_t,
        output ready, ready_t, product, product_t, productDone, productDone_t
    );
endinterface

// File: rtl/seq_multiplier_radix_taint_radix_pp_taint.sv
// Combinational partial product for one RUN cycle: digit * b, placed at bit
// position `shift`, together with its conservative taint.
//   digit, digit_t : current multiplier digit and its taint
//   b, b_t         : multiplicand magnitude and its taint
//   shift          : weight of the digit (cnt * BITS_PER_CYCLE)
//   pp, pp_t       : positioned partial product and its taint
module radix_pp_taint #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int SHIFT_W        = 6
) (
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [BITS_PER_CYCLE-1:0] digit_t,
    input  logic [WIDTH-1:0]          b,
    input  logic [WIDTH-1:0]          b_t,
    input  logic [SHIFT_W-1:0]        shift,
    output logic [2*WIDTH-1:0]        pp,
    output logic [2*WIDTH-1:0]        pp_t
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] b_ext;
    logic [PW-1:0] bt_ext;
    logic [PW-1:0] d_ext;

    assign b_ext  = {{WIDTH{1'b0}}, b};
    assign bt_ext = {{WIDTH{1'b0}}, b_t};
    assign d_ext  = {{(PW-BITS_PER_CYCLE){1'b0}}, digit};

    assign pp = (b_ext * d_ext) << shift;

    // A tainted digit can select any multiple of b, so everything from its
    // weight upward is suspect. A known non-zero digit only exposes b's taint;
    // a known zero digit contributes nothing.
    always_comb begin
        pp_t = '0;
        if (|digit_t) begin
            pp_t = {PW{1'b1}} << shift;
        end else if (digit != '0) begin
            pp_t = bt_ext << shift;
        end
    end
endmodule

// File: rtl/seq_multiplier_radix_taint.sv
// Taint-tracked sequential multiplier retiring BITS_PER_CYCLE multiplier bits
// per cycle, with optional two's-complement operands. Fixed latency N+3 from
// accept to productDone, N = WIDTH / BITS_PER_CYCLE.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : request (start, signed_mode, operands) and response (ready,
//         product, productDone), each with a shadow taint
// WIDTH must be >= 2 and <= 128; BITS_PER_CYCLE in {1,2,4} dividing WIDTH.
module seq_multiplier_radix_taint
    import seq_multiplier_radix_taint_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_multiplier_radix_taint_if.slave bus
);
    localparam int PW      = 2 * WIDTH;
    localparam int N       = WIDTH / BITS_PER_CYCLE;
    localparam int CW      = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam int SHIFT_W = $clog2(PW);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_reg, a_t, b_reg, b_t;
    logic              mode, mode_t, neg, neg_t, ctrl_t;
    logic [PW-1:0]     acc, acc_t, product, product_t;
    logic [PW-1:0]     pp, pp_t;
    logic [SHIFT_W-1:0] shift;
    logic              ready, done, run_last;

    // RUN lasts N+1 cycles: N accumulating digits, then one cycle at cnt == N
    // that only hands over to FIX. This keeps latency at N+3.
    assign run_last = (cnt == CW'(N));
    assign shift    = SHIFT_W'(int'(cnt) * BITS_PER_CYCLE);

    radix_pp_taint #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHIFT_W        (SHIFT_W)
    ) u_pp (
        .digit   (a_reg[BITS_PER_CYCLE-1:0]),
        .digit_t (a_t[BITS_PER_CYCLE-1:0]),
        .b       (b_reg),
        .b_t     (b_t),
        .shift   (shift),
        .pp      (pp),
        .pp_t    (pp_t)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) state_nxt = LOAD;
            end
            LOAD:    state_nxt = RUN;
            RUN:     if (run_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: every datapath and shadow register is cleared, not just the
            // control state: product and all taints must read 0 after reset.
            cnt       <= '0;
            a_reg     <= '0;
            a_t       <= '0;
            b_reg     <= '0;
            b_t       <= '0;
            mode      <= 1'b0;
            mode_t    <= 1'b0;
            neg       <= 1'b0;
            neg_t     <= 1'b0;
            ctrl_t    <= 1'b0;
            acc       <= '0;
            acc_t     <= '0;
            product   <= '0;
            product_t <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ctrl_t <= bus.start_t;
                    if (bus.start) begin
                        a_reg  <= bus.multiplier;
                        a_t    <= bus.multiplier_t;
                        b_reg  <= bus.multiplicand;
                        b_t    <= bus.multiplicand_t;
                        mode   <= bus.signed_mode;
                        mode_t <= bus.signed_mode_t;
                    end
                end
                LOAD: begin
                    // -x of the most-negative value wraps to itself, which read
                    // as unsigned is exactly the magnitude 2^(W-1).
                    if (mode) begin
                        a_reg <= a_reg[WIDTH-1] ? -a_reg : a_reg;
                        b_reg <= b_reg[WIDTH-1] ? -b_reg : b_reg;
                    end
                    neg <= mode & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    // A possibly-taken conditional negate carries upward from
                    // the lowest tainted bit, hence the smear.
                    if (mode || mode_t) begin
                        a_t   <= WIDTH'(smear(SMEAR_W'(a_t)));
                        b_t   <= WIDTH'(smear(SMEAR_W'(b_t)));
                        neg_t <= mode_t | a_t[WIDTH-1] | b_t[WIDTH-1];
                    end else begin
                        neg_t <= 1'b0;
                    end
                    acc   <= '0;
                    acc_t <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    if (!run_last) begin
                        acc   <= acc + pp;
                        acc_t <= PW'(smear(SMEAR_W'(acc_t | pp_t)));
                        a_reg <= a_reg >> BITS_PER_CYCLE;
                        a_t   <= a_t >> BITS_PER_CYCLE;
                        cnt   <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    product <= neg ? -acc : acc;
                    if (neg_t)    product_t <= {PW{1'b1}};
                    else if (neg) product_t <= PW'(smear(SMEAR_W'(acc_t)));
                    else          product_t <= acc_t;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready         = ready;
    assign bus.ready_t       = ctrl_t;
    assign bus.productDone   = done;
    assign bus.productDone_t = ctrl_t;
    assign bus.product       = product;
    assign bus.product_t     = product_t;
endmodule

// File: tb/tb_seq_multiplier_radix_taint.sv
// Directed bench for seq_multiplier_radix_taint at WIDTH=8, BITS_PER_CYCLE=2.
// Expected results come from a behavioural model pushed to a scoreboard queue
// at drive time and popped when productDone is seen.
module tb_seq_multiplier_radix_taint;
    localparam int W   = 8;
    localparam int LAT = 7;   // N + 3 with N = 4

    typedef struct {
        logic [15:0] product;
        logic [15:0] product_t;
        logic        done_t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_radix_taint_if #(.WIDTH(W)) bus ();

    seq_multiplier_radix_taint #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] smear16(input logic [15:0] x);
        logic [15:0] r;
        logic        seen;
        r    = '0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seen = seen | x[i];
            r[i] = seen;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sm, input logic sm_t,
                                   input logic [7:0] a_t, input logic [7:0] b_t,
                                   input logic st);
        exp_t        e;
        logic [15:0] sa, sbv, acc_t, pp_t, tmp;
        logic [7:0]  am, at, bt;
        logic [1:0]  d, dt;
        logic        neg, nt;
        sa  = {{8{a[7]}}, a};
        sbv = {{8{b[7]}}, b};
        if (sm) e.product = sa * sbv;
        else    e.product = {8'b0, a} * {8'b0, b};
        am  = (sm && a[7]) ? 8'(-a) : a;
        neg = sm & (a[7] ^ b[7]);
        at  = a_t;
        bt  = b_t;
        nt  = 1'b0;
        if (sm || sm_t) begin
            nt  = sm_t | a_t[7] | b_t[7];
            tmp = smear16({8'b0, a_t});
            at  = tmp[7:0];
            tmp = smear16({8'b0, b_t});
            bt  = tmp[7:0];
        end
        acc_t = '0;
        for (int i = 0; i < 4; i++) begin
            d  = am[2*i +: 2];
            dt = at[2*i +: 2];
            if (dt != 2'b00)     pp_t = 16'hFFFF << (2 * i);
            else if (d != 2'b00) pp_t = {8'b0, bt} << (2 * i);
            else                 pp_t = '0;
            acc_t = smear16(acc_t | pp_t);
        end
        if (nt)       e.product_t = 16'hFFFF;
        else if (neg) e.product_t = smear16(acc_t);
        else          e.product_t = acc_t;
        e.done_t = st;
        return e;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic sm_t, input logic [7:0] a_t, input logic [7:0] b_t,
                         input logic st);
        bus.multiplier     = a;
        bus.multiplicand   = b;
        bus.signed_mode    = sm;
        bus.signed_mode_t  = sm_t;
        bus.multiplier_t   = a_t;
        bus.multiplicand_t = b_t;
        bus.start_t        = st;
        bus.start          = 1'b1;
        sb.push_back(model(a, b, sm, sm_t, a_t, b_t, st));
    endtask

    task automatic accept_now(input string tag);
        check({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
        tick();
        acc_cyc = cyc;
        check({tag, "_ready_busy"}, 32'(bus.ready), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.productDone === 1'b1) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_product"},   32'(bus.product),       32'(e.product));
            check({tag, "_product_t"}, 32'(bus.product_t),     32'(e.product_t));
            check({tag, "_done_t"},    32'(bus.productDone_t), 32'(e.done_t));
        end
        tick();
        check({tag, "_pulse_end"}, 32'(bus.productDone), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int pulses;
        rst                = 1'b0;
        bus.start          = 1'b0;
        bus.start_t        = 1'b0;
        bus.signed_mode    = 1'b0;
        bus.signed_mode_t  = 1'b0;
        bus.multiplier     = '0;
        bus.multiplier_t   = '0;
        bus.multiplicand   = '0;
        bus.multiplicand_t = '0;
        tick();
        tick();
        check("rst_ready",     32'(bus.ready),         32'd1);
        check("rst_done",      32'(bus.productDone),   32'd0);
        check("rst_product",   32'(bus.product),       32'd0);
        check("rst_product_t", 32'(bus.product_t),     32'd0);
        check("rst_ready_t",   32'(bus.ready_t),       32'd0);
        check("rst_done_t",    32'(bus.productDone_t), 32'd0);
        rst = 1'b1;
        tick();

        // Unsigned, untainted.
        drive(8'd200, 8'd150, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        accept_now("u200x150");
        bus.start = 1'b0;
        wait_done("u200x150");

        // Signed back-to-back with start held: second accept on the IDLE
        // cycle after DONE.
        drive(8'hFD, 8'd5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        accept_now("s_m3x5");
        drive(8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        wait_done("s_m3x5");
        tick();
        acc_cyc = cyc;
        check("s_min_accept", 32'(bus.ready), 32'd0);
        bus.start = 1'b0;
        wait_done("s_min_x_min");

        // One tainted multiplicand bit.
        drive(8'd200, 8'd150, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
        accept_now("taint_b0");
        bus.start = 1'b0;
        wait_done("taint_b0");

        // Tainted start: control taint holds until IDLE samples start_t=0.
        drive(8'd7, 8'd9, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        accept_now("start_t");
        bus.start   = 1'b0;
        bus.start_t = 1'b0;
        tick();
        tick();
        check("start_t_ready_t_run", 32'(bus.ready_t), 32'd1);
        wait_done("start_t");
        check("start_t_ready_t_idle", 32'(bus.ready_t), 32'd1);
        tick();
        check("start_t_cleared", 32'(bus.ready_t), 32'd0);

        // Tainted signed_mode poisons the whole product.
        drive(8'h12, 8'h34, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        accept_now("mode_t");
        bus.start = 1'b0;
        wait_done("mode_t");

        // start pulsed during RUN is ignored.
        drive(8'h9C, 8'h63, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        accept_now("ignore");
        bus.start = 1'b0;
        tick();
        tick();
        bus.multiplier   = 8'h01;
        bus.multiplicand = 8'h01;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("ignore");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.productDone === 1'b1) pulses++;
        end
        check("ignore_no_queue", 32'(pulses), 32'd0);

        // Reset during RUN at cnt=3 with tainted inputs: abort without a pulse.
        bus.multiplier     = 8'd5;
        bus.multiplicand   = 8'd6;
        bus.multiplicand_t = 8'h10;
        bus.start_t        = 1'b1;
        bus.start          = 1'b1;
        accept_now("abort");
        bus.start   = 1'b0;
        bus.start_t = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_ready",     32'(bus.ready),         32'd1);
        check("abort_done",      32'(bus.productDone),   32'd0);
        check("abort_product",   32'(bus.product),       32'd0);
        check("abort_product_t", 32'(bus.product_t),     32'd0);
        check("abort_ready_t",   32'(bus.ready_t),       32'd0);
        check("abort_done_t",    32'(bus.productDone_t), 32'd0);
        bus.multiplicand_t = 8'h00;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.productDone === 1'b1) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);

        // Largest unsigned operands after the abort.
        drive(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        accept_now("u255x255");
        bus.start = 1'b0;
        wait_done("u255x255");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
